rx_frame_store: RTL and testbench
=================================

Name: rx_frame_store

Overview:
- Frame-aware store-and-forward buffer between a MAC receive byte stream and the opposite port's tx_control.
- Bytes are written speculatively and committed only when the frame ends with a good status; bad or overflowing frames are rolled back and dropped.
- The read side delivers whole committed frames, each with its length, so tx_control never starts a frame it cannot finish.
- Also produces the almost_full indication consumed by rx_control for pause generation.

Parameters:
ADDR_W, 11, log2 of byte storage depth (DEPTH = 2**ADDR_W = 2048 bytes)
LQ_AW, 3, log2 of frame-length queue depth (8 frames)
AF_MARGIN, 256, almost_full asserted when free bytes < AF_MARGIN

Ports:
clk  in  1  single clock for both sides
rst_n  in  1  asynchronous active-low reset
wr_valid  in  1  receive byte strobe
wr_data  in  8  receive byte
wr_last  in  1  final byte of frame, qualified by wr_valid
wr_err  in  1  frame bad (CRC/length error), sampled with wr_valid && wr_last
rd_valid  out  1  rd_data holds a byte of a committed frame
rd_ready  in  1  consumer accepts byte
rd_data  out  8  output byte
rd_last  out  1  rd_data is final byte of frame
frm_len  out  16  byte count of the frame at head of queue; stable from first byte until rd_last handshake
frm_len_valid  out  1  frm_len meaningful (head frame present)
almost_full  out  1  registered free-space warning
frame_cnt  out  LQ_AW+1  committed frames not yet fully read
drop_cnt  out  16  saturating count of dropped frames

Behaviour:
- Reset: all pointers, counters, flags 0; rd_valid=0, rd_last=0, frm_len_valid=0, almost_full=0, drop_cnt=0, frame_cnt=0. Reset mid-frame discards all stored and partial data.
- Pointers: ADDR_W+1 bits (wrap bit). wr_com = committed end, wr_spec = speculative write position, rd_ptr = read position. used = wr_spec - rd_ptr (modulo 2**(ADDR_W+1)).
- Write states: IDLE, FILL, DISCARD.
  - IDLE: wr_valid -> store byte, wr_spec++, go FILL; if wr_last on the same cycle, handle as end-of-frame.
  - FILL: each wr_valid stores a byte and increments wr_spec and a 16-bit speculative length.
  - Store with used==DEPTH -> byte not written, go DISCARD.
  - DISCARD: ignore bytes until wr_last.
- End of frame (wr_valid && wr_last) commits when all hold: wr_err=0, not DISCARD, length queue not full, length >= 1. Commit: the last byte is written, wr_com <= wr_spec+1, length pushed.
- Otherwise drop: wr_spec <= wr_com, drop_cnt++ saturating at 16'hFFFF.
- In all end-of-frame cases return to IDLE.
- Read: head frame present when length queue non-empty. Output register prefetches from memory.
  - First byte of a committed frame: rd_valid rises 2 cycles after the commit edge.
  - Steady state: 1 byte/cycle while rd_ready=1.
  - rd_valid never asserted for bytes beyond wr_com.
  - Remaining-byte counter loads frm_len; rd_last=1 when remaining==1. The rd_last handshake pops the length queue.
  - rd_ready low: rd_data, rd_last, rd_valid held.
- frame_cnt: +1 on commit, -1 on pop; unchanged on a simultaneous commit and pop.
- almost_full: registered, (DEPTH - used) < AF_MARGIN, updated every cycle. Uses wr_spec, so in-progress frames count.
- Read and write on the same cycle at full/empty boundaries are legal. A byte freed by a read is usable by a write on the next cycle, not the same cycle.

Optional Feature:
- Macro RX_FRAME_STORE_FCS_STRIP_EN.
- When defined:
  - Committed length = received bytes - 4.
  - Frames with received length <= 4 are dropped (drop_cnt++).
  - On rd_last handshake, rd_ptr advances past the 4 FCS bytes, so FCS is never presented; frm_len excludes FCS.
- When undefined: all bytes are stored and presented, and frm_len = received bytes.

Test Plan:
- Single 64-byte good frame, rd_ready=1 -> rd_valid 2 cycles after commit; 64 bytes in order; rd_last on byte 64; frm_len=64; frame_cnt 1->0.
- 60-byte frame with wr_err=1, then 60-byte good frame -> only the second frame read out; drop_cnt=1; no bytes from the first frame appear.
- rd_ready=0, then write 2100-byte frame -> DISCARD entered at byte 2049; frame dropped; drop_cnt=1; wr_spec restored; almost_full=1 during fill, 0 after rollback.
- Nine 10-byte good frames, rd_ready=0 -> 8 committed; ninth dropped (queue full); frame_cnt=8; drop_cnt=1.
- rd_ready toggled 1/0 every cycle across 3 back-to-back frames -> no duplicated or lost byte; rd_data held while rd_ready=0; rd_last exactly 3 times.
- With RX_FRAME_STORE_FCS_STRIP_EN: 68-byte frame gives frm_len=64 with the last 4 bytes never output; a 4-byte frame is dropped. Then reset asserted mid-frame -> all outputs 0 and the next frame reads out cleanly.

Source files
------------

// File: rtl/rx_frame_store_if.sv
// Byte-stream handshake bundle between the MAC receive path, rx_frame_store and tx_control.
// The slave modport is the buffer's view. The master modport is the producer/consumer view.
interface rx_frame_store_if;
    logic        wr_valid;
    logic [7:0]  wr_data;
    logic        wr_last;
    logic        wr_err;
    logic        rd_valid;
    logic        rd_ready;
    logic [7:0]  rd_data;
    logic        rd_last;
    logic [15:0] frm_len;
    logic        frm_len_valid;

    modport master (
        output wr_valid, wr_data, wr_last, wr_err, rd_ready,
        input  rd_valid, rd_data, rd_last, frm_len, frm_len_valid
    );

    modport slave (
        input  wr_valid, wr_data, wr_last, wr_err, rd_ready,
        output rd_valid, rd_data, rd_last, frm_len, frm_len_valid
    );
endinterface

// File: rtl/rx_frame_store.sv
// Frame-aware store-and-forward receive buffer: speculative writes, commit/rollback, whole-frame read-out.
// Optional macro RX_FRAME_STORE_FCS_STRIP_EN removes the trailing 4-byte FCS from every committed frame.
module rx_frame_store #(
    parameter int ADDR_W    = 11,
    parameter int LQ_AW     = 3,
    parameter int AF_MARGIN = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    rx_frame_store_if.slave    bus,
    output logic               almost_full,
    output logic [LQ_AW:0]     frame_cnt,
    output logic [15:0]        drop_cnt
);
    localparam int DEPTH    = 2**ADDR_W;
    localparam int LQ_DEPTH = 2**LQ_AW;
    localparam int PW       = ADDR_W + 1;
`ifdef RX_FRAME_STORE_FCS_STRIP_EN
    localparam int FCS_BYTES = 4;
`else
    localparam int FCS_BYTES = 0;
`endif
    localparam logic [PW-1:0]  DEPTH_P     = PW'(DEPTH);
    localparam logic [PW-1:0]  PTR_ONE     = PW'(1);
    localparam logic [PW-1:0]  FCS_PTR     = PW'(FCS_BYTES);
    localparam logic [15:0]    FCS_LEN     = 16'(FCS_BYTES);
    localparam logic [31:0]    AF_M        = 32'(AF_MARGIN);
    localparam logic [LQ_AW:0] LQ_FULL_CNT = (LQ_AW+1)'(LQ_DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_DISCARD} wr_state_t;

    logic [7:0]       mem [DEPTH];
    logic [15:0]      lq_mem [LQ_DEPTH];

    wr_state_t        state_reg;
    logic [PW-1:0]    wr_spec_reg, wr_com_reg, rd_ptr_reg;
    logic [15:0]      spec_len_reg;
    logic [LQ_AW-1:0] lq_wptr_reg, lq_rptr_reg;
    logic [LQ_AW:0]   frame_cnt_reg;
    logic [15:0]      drop_cnt_reg;
    logic             af_reg;
    logic             rd_active_reg, rd_valid_reg, rd_last_reg;
    logic [15:0]      fetch_rem_reg, frm_len_reg;
    logic [7:0]       rd_data_reg;

    logic [PW-1:0]    used_w, free_w;
    logic [15:0]      rx_len_w, com_len_w, lq_head_w;
    logic             mem_full_w, lq_full_w, eof_w, store_w, commit_w;
    logic             rd_hs_w, pop_w, fetch_w;

    assign used_w     = wr_spec_reg - rd_ptr_reg;
    assign free_w     = DEPTH_P - used_w;
    assign mem_full_w = (used_w == DEPTH_P);
    assign lq_full_w  = (frame_cnt_reg == LQ_FULL_CNT);
    assign eof_w      = bus.wr_valid && bus.wr_last;
    assign store_w    = bus.wr_valid && (state_reg != ST_DISCARD) && !mem_full_w;
    assign rx_len_w   = spec_len_reg + 16'd1;
    assign com_len_w  = rx_len_w - FCS_LEN;
    // The last byte must itself fit, so a full memory on the final byte also drops the frame.
    assign commit_w   = eof_w && !bus.wr_err && (state_reg != ST_DISCARD) && !mem_full_w
                        && !lq_full_w && (rx_len_w > FCS_LEN);
    assign lq_head_w  = lq_mem[lq_rptr_reg];
    assign rd_hs_w    = rd_valid_reg && bus.rd_ready;
    assign pop_w      = rd_hs_w && rd_last_reg;
    assign fetch_w    = rd_active_reg && (fetch_rem_reg != 16'd0) && (!rd_valid_reg || bus.rd_ready);

    // Storage arrays carry no reset so they map onto block RAM; rd_data is the RAM output register.
    always_ff @(posedge clk) begin
        if (store_w)
            mem[wr_spec_reg[ADDR_W-1:0]] <= bus.wr_data;
        if (fetch_w)
            rd_data_reg <= mem[rd_ptr_reg[ADDR_W-1:0]];
        if (commit_w)
            lq_mem[lq_wptr_reg] <= com_len_w;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            wr_spec_reg  <= '0;
            wr_com_reg   <= '0;
            spec_len_reg <= '0;
            lq_wptr_reg  <= '0;
            drop_cnt_reg <= '0;
        end else if (bus.wr_valid) begin
            if (bus.wr_last) begin
                state_reg    <= ST_IDLE;
                spec_len_reg <= '0;
                if (commit_w) begin
                    wr_spec_reg <= wr_spec_reg + PTR_ONE;
                    wr_com_reg  <= wr_spec_reg + PTR_ONE;
                    lq_wptr_reg <= lq_wptr_reg + 1'b1;
                end else begin
                    wr_spec_reg <= wr_com_reg;
                    if (drop_cnt_reg != 16'hFFFF)
                        drop_cnt_reg <= drop_cnt_reg + 16'd1;
                end
            end else if (state_reg != ST_DISCARD) begin
                if (mem_full_w) begin
                    state_reg <= ST_DISCARD;
                end else begin
                    wr_spec_reg  <= wr_spec_reg + PTR_ONE;
                    spec_len_reg <= spec_len_reg + 16'd1;
                    state_reg    <= ST_FILL;
                end
            end
        end
    end

    // A frame is activated one cycle after it appears in the length queue; bytes are fetched the cycle after.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_reg    <= '0;
            lq_rptr_reg   <= '0;
            rd_active_reg <= 1'b0;
            fetch_rem_reg <= '0;
            frm_len_reg   <= '0;
            rd_valid_reg  <= 1'b0;
            rd_last_reg   <= 1'b0;
        end else begin
            if (fetch_w) begin
                rd_ptr_reg    <= rd_ptr_reg + PTR_ONE;
                fetch_rem_reg <= fetch_rem_reg - 16'd1;
                rd_valid_reg  <= 1'b1;
                rd_last_reg   <= (fetch_rem_reg == 16'd1);
            end else if (rd_hs_w) begin
                rd_valid_reg <= 1'b0;
                rd_last_reg  <= 1'b0;
            end
            if (pop_w) begin
                rd_active_reg <= 1'b0;
                lq_rptr_reg   <= lq_rptr_reg + 1'b1;
                rd_ptr_reg    <= rd_ptr_reg + FCS_PTR;
            end else if (!rd_active_reg && (frame_cnt_reg != '0)) begin
                rd_active_reg <= 1'b1;
                fetch_rem_reg <= lq_head_w;
                frm_len_reg   <= lq_head_w;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_reg <= '0;
            af_reg        <= 1'b0;
        end else begin
            af_reg <= (32'(free_w) < AF_M);
            case ({commit_w, pop_w})
                2'b10:   frame_cnt_reg <= frame_cnt_reg + 1'b1;
                2'b01:   frame_cnt_reg <= frame_cnt_reg - 1'b1;
                default: frame_cnt_reg <= frame_cnt_reg;
            endcase
        end
    end

    assign bus.rd_valid      = rd_valid_reg;
    assign bus.rd_data       = rd_data_reg;
    assign bus.rd_last       = rd_last_reg;
    assign bus.frm_len       = frm_len_reg;
    assign bus.frm_len_valid = rd_active_reg;
    assign almost_full       = af_reg;
    assign frame_cnt         = frame_cnt_reg;
    assign drop_cnt          = drop_cnt_reg;
endmodule

// File: tb/tb_rx_frame_store.sv
// Self-checking bench for rx_frame_store: frame table, directed corner cases, randomized traffic vs a queue model.
// Honours RX_FRAME_STORE_FCS_STRIP_EN so the model strips the FCS when the design does.
module tb_rx_frame_store;
    localparam int ADDR_W    = 11;
    localparam int LQ_AW     = 3;
    localparam int AF_MARGIN = 256;
`ifdef RX_FRAME_STORE_FCS_STRIP_EN
    localparam int FCS_N = 4;
`else
    localparam int FCS_N = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic almost_full;
    logic [LQ_AW:0] frame_cnt;
    logic [15:0] drop_cnt;

    rx_frame_store_if bus();

    rx_frame_store #(.ADDR_W(ADDR_W), .LQ_AW(LQ_AW), .AF_MARGIN(AF_MARGIN)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .almost_full(almost_full), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail = 0;
    int cyc = 0;
    int rdy_mode = 0;   // 0 low, 1 high, 2 toggle, 3 random

    // Reference model: bytes and frame lengths that must come out, in order.
    logic [7:0] exp_data[$];
    bit         exp_last[$];
    int         exp_len[$];
    int model_drops = 0;
    int model_commits = 0;
    int mon_frames = 0;
    int mon_lasts = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       bus.rd_ready = 1'b0;
            1:       bus.rd_ready = 1'b1;
            2:       bus.rd_ready = ~bus.rd_ready;
            default: bus.rd_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Output monitor: a handshake seen at the negedge completes on the following posedge.
    logic [7:0] hold_data;
    logic       hold_last;
    bit         hold_pend = 0;
    bit         mon_first = 1;
    bit         eb;
    int         cur_len = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pend = 0;
            mon_first = 1;
        end else begin
            if (hold_pend) begin
                chk("hold_rd_valid", bus.rd_valid, 1);
                chk("hold_rd_data", bus.rd_data, hold_data);
                chk("hold_rd_last", bus.rd_last, hold_last);
                hold_pend = 0;
            end
            if (bus.rd_valid && bus.rd_ready) begin
                if (exp_data.size() == 0) begin
                    chk("rd_valid_without_frame", bus.rd_valid, 0);
                end else begin
                    if (mon_first) begin
                        cur_len = exp_len.pop_front();
                        chk("frm_len_valid", bus.frm_len_valid, 1);
                    end
                    chk("frm_len", bus.frm_len, cur_len);
                    chk("rd_data", bus.rd_data, exp_data.pop_front());
                    eb = exp_last.pop_front();
                    chk("rd_last", bus.rd_last, eb);
                    mon_first = eb;
                    if (eb) mon_frames++;
                end
                if (bus.rd_last) mon_lasts++;
            end else if (bus.rd_valid) begin
                hold_pend = 1;
                hold_data = bus.rd_data;
                hold_last = bus.rd_last;
            end
        end
    end

    task automatic send_frame(input int len, input bit err, input bit commit, input int gap_pct,
                              input int af_idx, output int last_cyc);
        logic [7:0] b[$];
        last_cyc = 0;
        for (int i = 0; i < len; i++) begin
            while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                @(posedge clk); #1;
                bus.wr_valid = 1'b0; bus.wr_last = 1'b0; bus.wr_err = 1'b0;
            end
            @(posedge clk); #1;
            b.push_back(8'($urandom));
            bus.wr_valid = 1'b1;
            bus.wr_data  = b[i];
            bus.wr_last  = (i == len - 1);
            bus.wr_err   = err && (i == len - 1);
            if (i == len - 1) last_cyc = cyc;
            if (i == af_idx) begin
                @(negedge clk);
                chk("almost_full_during_fill", almost_full, 1);
            end
        end
        @(posedge clk); #1;
        bus.wr_valid = 1'b0; bus.wr_last = 1'b0; bus.wr_err = 1'b0;
        if (commit) begin
            model_commits++;
            exp_len.push_back(len - FCS_N);
            for (int i = 0; i < len - FCS_N; i++) begin
                exp_data.push_back(b[i]);
                exp_last.push_back(i == len - FCS_N - 1);
            end
        end else begin
            model_drops++;
        end
        $display("frame len=%0d err=%0d expect_commit=%0d drops=%0d", len, err, commit, model_drops);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_data.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_bytes_left", exp_data.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    typedef struct {
        int len;
        bit err;
        bit commit;
        int exp_fcnt;
        int exp_drops;
    } vec_t;
    vec_t tbl[10];

    initial begin
        int lc, fc, dr, seen, l0, n, len;
        bit err;
        // Frame table applied with rd_ready low: error frame, tiny frame, then enough to overfill the queue.
        fc = 0; dr = 0;
        for (int i = 0; i < 10; i++) begin
            len = (i == 0) ? 60 : (i == 1) ? 4 : 10;
            err = (i == 0);
            tbl[i].len = len;
            tbl[i].err = err;
            tbl[i].commit = !err && (len > FCS_N) && (fc < 8);
            if (tbl[i].commit) fc++; else dr++;
            tbl[i].exp_fcnt = fc;
            tbl[i].exp_drops = dr;
        end

        bus.wr_valid = 1'b0; bus.wr_data = 8'h00; bus.wr_last = 1'b0; bus.wr_err = 1'b0;
        bus.rd_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_rd_valid", bus.rd_valid, 0);
        chk("reset_rd_last", bus.rd_last, 0);
        chk("reset_frm_len_valid", bus.frm_len_valid, 0);
        chk("reset_almost_full", almost_full, 0);
        chk("reset_frame_cnt", frame_cnt, 0);
        chk("reset_drop_cnt", drop_cnt, 0);

        rdy_mode = 0;
        for (int i = 0; i < 10; i++) begin
            send_frame(tbl[i].len, tbl[i].err, tbl[i].commit, 0, -1, lc);
            @(negedge clk);
            chk("tbl_frame_cnt", frame_cnt, tbl[i].exp_fcnt);
            chk("tbl_drop_cnt", drop_cnt, tbl[i].exp_drops);
        end
        rdy_mode = 1;
        drain(3000);
        chk("tbl_drained_frame_cnt", frame_cnt, 0);

        // First-byte latency on an idle reader.
        send_frame(64, 0, 1, 0, -1, lc);
        @(negedge clk);
        chk("lat_frame_cnt_after_commit", frame_cnt, 1);
        seen = -1;
        for (int k = 0; k < 20 && seen < 0; k++) begin
            if (bus.rd_valid) seen = cyc - lc;
            else @(negedge clk);
        end
        chk("first_byte_latency", seen, 3);
        l0 = mon_lasts;
        drain(500);
        chk("lat_rd_last_count", mon_lasts - l0, 1);
        chk("lat_frame_cnt_end", frame_cnt, 0);

        // Overflow drop, then a frame that fills storage exactly.
        rdy_mode = 0;
        send_frame(2100, 0, 0, 0, 2000, lc);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("ovf_almost_full_after_rollback", almost_full, 0);
        chk("ovf_drop_cnt", drop_cnt, model_drops);
        chk("ovf_frame_cnt", frame_cnt, 0);
        send_frame(2048, 0, 1, 0, -1, lc);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("full_almost_full", almost_full, 1);
        chk("full_frame_cnt", frame_cnt, 1);
        rdy_mode = 1;
        drain(5000);
        chk("full_almost_full_after_drain", almost_full, 0);
        chk("full_frame_cnt_end", frame_cnt, 0);

        // Back-to-back frames against a toggling consumer.
        rdy_mode = 2;
        l0 = mon_lasts;
        send_frame(20, 0, 1, 0, -1, lc);
        send_frame(9, 0, 1, 0, -1, lc);
        send_frame(30, 0, 1, 0, -1, lc);
        drain(1000);
        chk("toggle_rd_last_count", mon_lasts - l0, 3);

        // FCS handling on a 68-byte frame (frm_len checked by the monitor).
        rdy_mode = 1;
        send_frame(68, 0, 1, 0, -1, lc);
        drain(500);

        // Randomized traffic, flow-controlled so storage and length queue never overfill.
        rdy_mode = 3;
        for (int f = 0; f < 40; f++) begin
            n = 0;
            while ((model_commits - mon_frames) > 3 && n < 3000) begin
                @(negedge clk);
                n++;
            end
            if (n >= 3000) chk("flow_wait_outstanding", model_commits - mon_frames, 3);
            len = $urandom_range(1, 100);
            err = ($urandom_range(0, 9) == 0);
            send_frame(len, err, !err && (len > FCS_N), $urandom_range(0, 30), -1, lc);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        rdy_mode = 1;
        drain(10000);
        chk("rand_drop_cnt", drop_cnt, model_drops);
        chk("rand_frame_cnt", frame_cnt, 0);

        // Reset in the middle of a frame with a committed frame waiting.
        rdy_mode = 0;
        send_frame(20, 0, 1, 0, -1, lc);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            bus.wr_valid = 1'b1; bus.wr_data = 8'(i); bus.wr_last = 1'b0; bus.wr_err = 1'b0;
        end
        #2;
        rst_n = 1'b0;
        bus.wr_valid = 1'b0;
        exp_data.delete(); exp_last.delete(); exp_len.delete();
        model_drops = 0; model_commits = 0; mon_frames = 0;
        #1;
        chk("midrst_rd_valid", bus.rd_valid, 0);
        chk("midrst_rd_last", bus.rd_last, 0);
        chk("midrst_frm_len_valid", bus.frm_len_valid, 0);
        chk("midrst_frm_len", bus.frm_len, 0);
        chk("midrst_almost_full", almost_full, 0);
        chk("midrst_frame_cnt", frame_cnt, 0);
        chk("midrst_drop_cnt", drop_cnt, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rdy_mode = 1;
        repeat (2) @(negedge clk);
        send_frame(30, 0, 1, 0, -1, lc);
        drain(500);
        chk("post_rst_frame_cnt", frame_cnt, 0);
        chk("post_rst_drop_cnt", drop_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, failures so far %0d", n_fail);
        $fatal(1, "watchdog");
    end
endmodule
